// File: rtl/bwt_pkg.sv
// Shared types and width helpers for the BWT job scheduler.
// No timing of its own; pure declarations.
package bwt_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    LOAD  = ST_LOAD,
    START = ST_START,
    WAIT  = ST_WAIT,
    DRAIN = ST_DRAIN
  } sched_state_e;

  localparam int unsigned DEF_STRING_LEN = 64;
  localparam int unsigned DEF_N_REQ      = 4;
  localparam int unsigned DEF_TIMEOUT    = 4096;

  // Index width that never collapses to zero for a single requester.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned rr_idx(input int unsigned p, input int unsigned k,
                                         input int unsigned n);
    return (p + k) % n;
  endfunction

endpackage

// File: rtl/bwt_job_scheduler_arb.sv
// Round-robin arbiter: first requester at or above ptr, wrapping; purely combinational.
// No backpressure; grant is one-hot, idx is its encoded position.
module rr_arbiter
  import bwt_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned IW = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    idx,
  output logic             any
);

  logic [IW-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = IW'(rr_idx(32'(ptr), k, N_REQ));
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/bwt_job_scheduler.sv
// Shares one BWT sort core among N_REQ requesters, one job at a time: load, start, wait, drain.
// Drain streams 1 byte/cycle, first byte 2 cycles after DRAIN entry; a 2-entry skid absorbs out_ready stalls.
module bwt_job_scheduler
  import bwt_pkg::*;
#(
  parameter int unsigned STRING_LEN = DEF_STRING_LEN,
  parameter int unsigned N_REQ      = DEF_N_REQ,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT,
  localparam int unsigned AW = $clog2(STRING_LEN),
  localparam int unsigned IW = idx_w(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*8-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic               core_wr_en,
  output logic [AW-1:0]      core_wr_addr,
  output logic [7:0]         core_wr_data,
  output logic               core_start,
  input  logic               core_done,
  output logic [AW-1:0]      core_rd_addr,
  input  logic [7:0]         core_rd_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         out_data,
  output logic [IW-1:0]      out_id,
  output logic               out_last,
  output logic               busy,
  output logic               err_timeout
);

  localparam int unsigned   TW        = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0] LAST_IDX  = AW'(STRING_LEN - 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(TIMEOUT - 1);
  localparam logic [IW-1:0] LAST_REQ  = IW'(N_REQ - 1);

  sched_state_e     state;
  logic [IW-1:0]    id_q, rr_ptr, next_ptr, arb_idx;
  logic [N_REQ-1:0] arb_grant, grant_q;
  logic             arb_any;
  logic [AW-1:0]    wr_cnt, rd_cnt;
  logic [TW-1:0]    timer;
  logic             rd_all, rd_pend, rd_pend_last;
  logic [1:0]       occ, fill;
  logic [1:0][7:0]  sk_dat;
  logic [1:0]       sk_last;
  logic             wr_hs, issue, pop;
  logic [7:0]       sel_byte;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  assign sel_byte     = req_data[{id_q, 3'b000} +: 8];
  assign wr_hs        = (state == LOAD) && req_valid[id_q];
  assign req_ready    = (state == LOAD) ? grant_q : '0;
  assign core_wr_en   = wr_hs;
  assign core_wr_addr = wr_cnt;
  assign core_wr_data = wr_hs ? sel_byte : 8'h00;
  assign core_start   = (state == START);
  assign core_rd_addr = rd_cnt;
  assign busy         = (state != IDLE);
  assign err_timeout  = (state == WAIT) && !core_done && (timer == LAST_TICK);
  assign next_ptr     = (id_q == LAST_REQ) ? '0 : id_q + IW'(1);

  assign out_valid = (occ != 2'd0);
  assign out_data  = sk_dat[0];
  assign out_id    = id_q;
  assign out_last  = out_valid && sk_last[0];
  assign pop       = out_valid && out_ready;

  // Credit counts the slot freed by a same-cycle pop so streaming never bubbles.
  assign fill  = occ - {1'b0, pop} + {1'b0, rd_pend};
  assign issue = (state == DRAIN) && !rd_all && (fill < 2'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      id_q         <= '0;
      grant_q      <= '0;
      rr_ptr       <= '0;
      wr_cnt       <= '0;
      timer        <= '0;
      rd_cnt       <= '0;
      rd_all       <= 1'b0;
      rd_pend      <= 1'b0;
      rd_pend_last <= 1'b0;
      occ          <= '0;
      sk_dat       <= '0;
      sk_last      <= '0;
    end else begin
      case (state)
        IDLE: if (arb_any) begin
          id_q    <= arb_idx;
          grant_q <= arb_grant;
          state   <= LOAD;
        end
        LOAD: if (wr_hs) begin
          if (wr_cnt == LAST_IDX) begin
            wr_cnt <= '0;
            state  <= START;
          end else begin
            wr_cnt <= wr_cnt + AW'(1);
          end
        end
        START: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (core_done) begin
            rd_cnt <= '0;
            rd_all <= 1'b0;
            state  <= DRAIN;
          end else if (timer == LAST_TICK) begin
            rr_ptr <= next_ptr;
            state  <= IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        DRAIN: if (pop && sk_last[0]) begin
          rr_ptr <= next_ptr;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (issue) begin
        if (rd_cnt == LAST_IDX) begin
          rd_all <= 1'b1;
          rd_cnt <= '0;
        end else begin
          rd_cnt <= rd_cnt + AW'(1);
        end
      end
      rd_pend      <= issue;
      rd_pend_last <= issue && (rd_cnt == LAST_IDX);

      // Head entry only moves on pop, so out_* hold while stalled.
      case ({rd_pend, pop})
        2'b10: begin
          if (occ == 2'd0) begin
            sk_dat[0]  <= core_rd_data;
            sk_last[0] <= rd_pend_last;
          end else begin
            sk_dat[1]  <= core_rd_data;
            sk_last[1] <= rd_pend_last;
          end
          occ <= occ + 2'd1;
        end
        2'b01: begin
          sk_dat[0]  <= sk_dat[1];
          sk_last[0] <= sk_last[1];
          occ        <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            sk_dat[0]  <= core_rd_data;
            sk_last[0] <= rd_pend_last;
          end else begin
            sk_dat[0]  <= sk_dat[1];
            sk_last[0] <= sk_last[1];
            sk_dat[1]  <= core_rd_data;
            sk_last[1] <= rd_pend_last;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
